spi_master: RTL and testbench

- SPI mode-0 master that drives the 24-bit command/payload link into the FPGA SPI slave. Frame format: bits [23:16] command, [15:0] payload, MSB first.
- Used as the host-side driver in loopback/bench builds and in the companion controller FPGA.
- A write is one frame.
- A read is two frames, because the slave loads its reply at the start of the frame that follows the command. The first frame carries the command. The second frame is a dummy frame, and the MISO bits captured during it form the reply.

---
 rtl/spi_master.sv | 191 +++++++++++++++++++
 tb/tb_spi_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : SPI mode-0 master for the 24-bit command/payload link.
//                Frame = {cmd[7:0], payload[15:0]}, MSB first.
//                A write is one frame. A read is a command frame and then a
//                dummy all-zero frame. The MISO bits captured during the
//                dummy frame are presented on rdata.
//  Ports       : clk, rst_n (async, active low)
//                start/rd/cmd/wdata : request, sampled only in IDLE
//                busy/done/rdata    : transaction status and read reply
//                SCK/SSEL/MOSI/MISO : SPI pins (SCK idles low, SSEL high)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int CLK_DIV  = 8,   // clk cycles per SCK half-period (>=4)
    parameter int CS_SETUP = 8,   // SSEL low to first SCK rise phase (>=4)
    parameter int CS_HOLD  = 8,   // last SCK fall to SSEL high
    parameter int CS_GAP   = 8    // SSEL high between the two read frames (>=4)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rd,
    input  logic [7:0]  cmd,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [23:0] rdata,
    output logic        SCK,
    output logic        SSEL,
    output logic        MOSI,
    input  logic        MISO
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_HOLD  = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam logic [15:0] c_DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] c_HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] c_HOLD_END   = 16'(CS_HOLD);
    localparam logic [15:0] c_GAP_LAST   = 16'(CS_GAP - 1);
    localparam logic [4:0]  c_BIT_LAST   = 5'd23;

    logic [2:0]  r_state;
    logic [15:0] r_cnt;       // shared phase counter for SETUP/SHIFT/HOLD/GAP
    logic [4:0]  r_bit;       // bit index 0..23 within the frame
    logic [23:0] r_sr;        // transmit shift register, bit 23 drives MOSI
    logic [23:0] r_cap;       // MISO capture register
    logic        r_rd;
    logic        r_second;    // set while the dummy frame of a read runs
    logic        r_sck;
    logic        r_ssel;
    logic        r_busy;
    logic [23:0] r_rdata;
    logic        r_miso_s1;
    logic        r_miso_s2;

    assign busy  = r_busy;
    assign done  = (r_state == c_ST_DONE);
    assign rdata = r_rdata;
    assign SCK   = r_sck;
    assign SSEL  = r_ssel;
    assign MOSI  = r_sr[23];

    // Two-flop synchroniser on the asynchronous slave data line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= MISO;
            r_miso_s2 <= r_miso_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= 16'd0;
            r_bit    <= 5'd0;
            r_sr     <= 24'd0;
            r_cap    <= 24'd0;
            r_rd     <= 1'b0;
            r_second <= 1'b0;
            r_sck    <= 1'b0;
            r_ssel   <= 1'b1;
            r_busy   <= 1'b0;
            r_rdata  <= 24'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        // Reads carry an all-zero payload regardless of wdata.
                        r_sr     <= {cmd, (rd ? 16'h0000 : wdata)};
                        r_rd     <= rd;
                        r_second <= 1'b0;
                        r_ssel   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= 16'd0;
                        r_state  <= c_ST_SETUP;
                    end
                end

                c_ST_SETUP: begin
                    if (r_cnt == c_SETUP_LAST) begin
                        r_cnt   <= 16'd0;
                        r_bit   <= 5'd0;
                        r_state <= c_ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                c_ST_SHIFT: begin
                    if (r_cnt == c_DIV_LAST) begin
                        r_cnt <= 16'd0;
                        if (!r_sck) begin
                            // Rising phase: sample the slave's bit.
                            r_sck <= 1'b1;
                            r_cap <= {r_cap[22:0], r_miso_s2};
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit == c_BIT_LAST) begin
                                r_bit   <= 5'd0;
                                r_state <= c_ST_HOLD;
                            end else begin
                                // Falling phase: present the next bit.
                                r_bit <= r_bit + 5'd1;
                                r_sr  <= {r_sr[22:0], 1'b0};
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                c_ST_HOLD: begin
                    // CS_HOLD cycles with SSEL low, then SSEL rises. A read's
                    // command frame goes straight into the gap; otherwise one
                    // SSEL-high cycle precedes DONE.
                    if (r_cnt == c_HOLD_LAST) begin
                        r_ssel <= 1'b1;
                        if (r_rd && !r_second) begin
                            r_cnt   <= 16'd0;
                            r_state <= c_ST_GAP;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else if (r_cnt == c_HOLD_END) begin
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_DONE;
                        if (r_rd) begin
                            r_rdata <= r_cap;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                c_ST_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt    <= 16'd0;
                        r_ssel   <= 1'b0;
                        r_second <= 1'b1;
                        r_sr     <= 24'h000000;
                        r_state  <= c_ST_SETUP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Self-checking bench for spi_master. Two instances (default
//                divider and CLK_DIV=4) share one behavioural slave model on
//                a merged bus; only one instance is active at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    typedef struct {
        bit          sel;      // 0 = instance A, 1 = instance B (CLK_DIV=4)
        bit          rd;
        logic [7:0]  cmd;
        logic [15:0] wdata;
        int          lat;      // start cycle to done cycle
        int          nfr;      // frames expected on the bus
        logic [23:0] f0;
        logic [23:0] f1;
        logic [23:0] rdata;
        int          t_start;
        int          fbase;
        int          rbase;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, rd;
    logic [7:0]  cmd;
    logic [15:0] wdata;
    logic        miso = 1'b0;
    logic        busy_a, done_a, sck_a, ssel_a, mosi_a;
    logic        busy_b, done_b, sck_b, ssel_b, mosi_b;
    logic [23:0] rdata_a, rdata_b;
    logic        ssel_bus, sck_bus, mosi_bus, busy_any;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    vec_t sb[$];
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ssel_bus = ssel_a & ssel_b;
    assign sck_bus  = sck_a | sck_b;
    assign mosi_bus = ssel_a ? mosi_b : mosi_a;
    assign busy_any = busy_a | busy_b;

    spi_master u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .rd(rd), .cmd(cmd),
        .wdata(wdata), .busy(busy_a), .done(done_a), .rdata(rdata_a),
        .SCK(sck_a), .SSEL(ssel_a), .MOSI(mosi_a), .MISO(miso)
    );

    spi_master #(.CLK_DIV(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .rd(rd), .cmd(cmd),
        .wdata(wdata), .busy(busy_b), .done(done_b), .rdata(rdata_b),
        .SCK(sck_b), .SSEL(ssel_b), .MOSI(mosi_b), .MISO(miso)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural slave ----------------
    // Captures MOSI on SCK rise, shifts MISO on SCK fall, loads the reply to
    // the previous command when SSEL falls, decodes the frame when SSEL rises.
    localparam logic [9:0]  c_PWMVALUE = 10'h2AB;
    localparam logic [11:0] c_IFFREQ   = 12'h5A5;
    logic [23:0] s_rx = '0, s_tx = '0, s_reply = '0;
    int          s_cnt = 0;
    logic        s_ssel_q = 1'b1, s_sck_q = 1'b0;
    logic [5:0]  satset = '0;
    logic [9:0]  pwmset = '0;
    logic [23:0] frames[$];
    int          rises = 0;

    always @(ssel_bus or sck_bus) begin
        if (s_ssel_q === 1'b1 && ssel_bus === 1'b0) begin
            s_cnt = 0;
            s_tx  = s_reply;
            miso  = s_tx[23];
        end else if (s_ssel_q === 1'b0 && ssel_bus === 1'b1 && s_cnt == 24) begin
            frames.push_back(s_rx);
            case (s_rx[23:16])
                // saturation set-point is stored as the count minus one
                8'h01:   begin satset = s_rx[5:0] - 6'd1; s_reply = {8'h01, 16'h0}; end
                8'h03:   begin pwmset = s_rx[9:0];        s_reply = {8'h03, 16'h0}; end
                8'h04:   s_reply = {8'h04, 6'b0, c_PWMVALUE};
                8'h05:   s_reply = {8'h05, 4'b0, c_IFFREQ};
                default: s_reply = {s_rx[23:16], 16'h0};
            endcase
        end
        if (ssel_bus === 1'b0 && s_sck_q === 1'b0 && sck_bus === 1'b1) begin
            s_rx = {s_rx[22:0], mosi_bus};
            s_cnt++;
            rises++;
        end
        if (ssel_bus === 1'b0 && s_sck_q === 1'b1 && sck_bus === 1'b0) begin
            s_tx = {s_tx[22:0], 1'b0};
            miso = s_tx[23];
        end
        s_ssel_q = ssel_bus;
        s_sck_q  = sck_bus;
    end

    // ---------------- scoreboard monitor ----------------
    logic busy_q = 1'b0;
    int   bcnt   = 0;

    always @(negedge clk) begin
        vec_t e;
        if (busy_any && !busy_q) bcnt = 1;
        else if (busy_any)       bcnt++;
        busy_q = busy_any;
        if (rst_n === 1'b1 && (done_a === 1'b1 || done_b === 1'b1)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: done at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_source", {31'b0, done_b}, {31'b0, e.sel});
                chk("latency", cyc - e.t_start, e.lat);
                chk("busy_span", bcnt, e.lat - 1);
                chk("busy_low_at_done", {31'b0, busy_any}, 32'd0);
                chk("rdata", e.sel ? rdata_b : rdata_a, e.rdata);
                chk("frame_count", frames.size() - e.fbase, e.nfr);
                chk("sck_rises", rises - e.rbase, 24 * e.nfr);
                if (frames.size() > e.fbase)
                    chk("frame0", frames[e.fbase], e.f0);
                if (e.nfr == 2 && frames.size() > e.fbase + 1)
                    chk("frame1", frames[e.fbase + 1], e.f1);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic vec_t mk(input bit sel, input bit r, input logic [7:0] c,
                                input logic [15:0] w, input int lat, input int nfr,
                                input logic [23:0] f0, input logic [23:0] f1,
                                input logic [23:0] rdat);
        vec_t v;
        v.sel = sel; v.rd = r; v.cmd = c; v.wdata = w; v.lat = lat; v.nfr = nfr;
        v.f0 = f0; v.f1 = f1; v.rdata = rdat; v.t_start = 0; v.fbase = 0; v.rbase = 0;
        return v;
    endfunction

    // Drives a one-cycle start and pushes the expectation; returns at the
    // negedge of the cycle after the start cycle.
    task automatic issue(input vec_t v);
        @(negedge clk);
        chk("ssel_idle", {31'b0, (v.sel ? ssel_b : ssel_a)}, 32'd1);
        rd = v.rd; cmd = v.cmd; wdata = v.wdata;
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
        v.t_start = cyc;
        v.fbase   = frames.size();
        v.rbase   = rises;
        sb.push_back(v);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk("ssel_fall", {31'b0, (v.sel ? ssel_b : ssel_a)}, 32'd0);
        chk("busy_rise", {31'b0, (v.sel ? busy_b : busy_a)}, 32'd1);
    endtask

    task automatic wait_done(input bit sel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if ((sel ? done_b : done_a) === 1'b1) seen = 1'b1;
        end
        chk("done_timeout", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; rd = 1'b0;
        cmd = 8'h00; wdata = 16'h0000;

        vecs[0] = mk(0, 0, 8'h02, 16'h0ABC, 402, 1, 24'h020ABC, 24'h0, 24'h000000);
        vecs[1] = mk(0, 1, 8'h04, 16'hFFFF, 810, 2, 24'h040000, 24'h0, 24'h0402AB);
        vecs[2] = mk(0, 0, 8'h01, 16'h0005, 402, 1, 24'h010005, 24'h0, 24'h0402AB);
        vecs[3] = mk(0, 0, 8'h03, 16'h03FF, 402, 1, 24'h0303FF, 24'h0, 24'h0402AB);
        vecs[4] = mk(1, 1, 8'h05, 16'h1234, 426, 2, 24'h050000, 24'h0, 24'h0505A5);
        vecs[5] = mk(1, 0, 8'h02, 16'h0ABC, 210, 1, 24'h020ABC, 24'h0, 24'h0505A5);

        repeat (3) @(negedge clk);
        chk("rst_ssel",  {31'b0, ssel_a}, 32'd1);
        chk("rst_sck",   {31'b0, sck_a},  32'd0);
        chk("rst_mosi",  {31'b0, mosi_a}, 32'd0);
        chk("rst_busy",  {31'b0, busy_a}, 32'd0);
        chk("rst_done",  {31'b0, done_a}, 32'd0);
        chk("rst_rdata", rdata_a, 32'd0);
        chk("rst_ssel_b", {31'b0, ssel_b}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i]);
            wait_done(vecs[i].sel);
        end
        chk("slave_satset", {26'b0, satset}, 32'd4);
        chk("slave_pwmset", {22'b0, pwmset}, 32'h3FF);

        // Start during SHIFT is ignored; a start right after done is taken.
        issue(mk(0, 0, 8'h02, 16'h5555, 402, 1, 24'h025555, 24'h0, 24'h0402AB));
        repeat (150) @(negedge clk);
        rd = 1'b1; cmd = 8'h7E; wdata = 16'h1111; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0);
        issue(mk(0, 0, 8'h02, 16'h00F0, 402, 1, 24'h0200F0, 24'h0, 24'h0402AB));
        wait_done(0);

        // Reset during bit 10 of a write.
        issue(mk(0, 0, 8'h02, 16'h0ABC, 402, 1, 24'h020ABC, 24'h0, 24'h0402AB));
        repeat (175) @(negedge clk);
        chk("mid_frame_ssel", {31'b0, ssel_a}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ssel", {31'b0, ssel_a}, 32'd1);
        chk("async_rst_sck",  {31'b0, sck_a},  32'd0);
        chk("async_rst_busy", {31'b0, busy_a}, 32'd0);
        chk("async_rst_mosi", {31'b0, mosi_a}, 32'd0);
        chk("async_rst_rdata", rdata_a, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(mk(0, 0, 8'h02, 16'h1234, 402, 1, 24'h021234, 24'h0, 24'h000000));
        wait_done(0);

        repeat (300) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
